// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: top-level game sequencer.
// Moves between MENU, the play levels and the FAIL screen. It charges the
// entry ticket, times each level from the 1 Hz tick and reports wins and
// rejected starts to the player/level logic.
module game_flow_ctrl #(
    parameter int TICKET_COST = 10,  // minimum money needed to start
    parameter int LEVEL_SECS  = 30,  // seconds per level (1..63)
    parameter int FAIL_SECS   = 3,   // seconds the FAIL screen is held (1..63)
    parameter int NUM_LEVELS  = 4    // last play level (1..4)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       sec_tick,
    input  logic       fail,
    input  logic [6:0] money,
    output logic [3:0] state,
    output logic       ticket,
    output logic [5:0] level_time,
    output logic       win,
    output logic       insufficient
);

    // State encodings seen on the state bus; 1..NUM_LEVELS are play levels.
    localparam logic [3:0] S_MENU = 4'd0;
    localparam logic [3:0] S_L1   = 4'd1;
    localparam logic [3:0] S_FAIL = 4'd5;

    localparam logic [3:0] LAST_LEVEL = 4'(NUM_LEVELS);
    localparam logic [5:0] LEVEL_T    = 6'(LEVEL_SECS);
    localparam logic [5:0] FAIL_T     = 6'(FAIL_SECS);
    localparam logic [6:0] COST       = 7'(TICKET_COST);

    logic [3:0] state_q, state_d;
    logic [5:0] level_time_q, level_time_d;
    logic       ticket_q, ticket_d;
    logic       win_q, win_d;
    logic       insufficient_q, insufficient_d;

    logic in_level;
    logic can_pay;
    logic expiring;

    assign in_level = (state_q >= S_L1) && (state_q <= LAST_LEVEL);
    assign can_pay  = (money >= COST);
    // Treat a zero count like the last second so the timer never wraps.
    assign expiring = (level_time_q <= 6'd1);

    // State register and registered outputs, synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            state_q        <= S_MENU;
            level_time_q   <= 6'd0;
            ticket_q       <= 1'b0;
            win_q          <= 1'b0;
            insufficient_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            level_time_q   <= level_time_d;
            ticket_q       <= ticket_d;
            win_q          <= win_d;
            insufficient_q <= insufficient_d;
        end
    end

    // Next-state decision; in play the priority is fail > abort > sec_tick.
    always_comb begin
        // NOTE: default first so no path through the case infers a latch.
        state_d = state_q;
        if (state_q == S_MENU) begin
            if (start && can_pay)
                state_d = S_L1;
        end else if (in_level) begin
            if (fail)
                state_d = S_FAIL;
            else if (abort)
                state_d = S_MENU;
            else if (sec_tick && expiring)
                state_d = (state_q < LAST_LEVEL) ? state_q + 4'd1 : S_MENU;
        end else if (state_q == S_FAIL) begin
            if (sec_tick && expiring)
                state_d = S_MENU;
        end else begin
            // Unused encodings fall back to MENU.
            state_d = S_MENU;
        end
    end

    // Next values of the registered outputs (timer, pulses, sticky flag).
    always_comb begin
        level_time_d   = level_time_q;
        ticket_d       = 1'b0;
        win_d          = 1'b0;
        insufficient_d = insufficient_q;
        if (state_q == S_MENU) begin
            level_time_d = 6'd0;
            if (start) begin
                if (can_pay) begin
                    level_time_d   = LEVEL_T;
                    ticket_d       = 1'b1;
                    insufficient_d = 1'b0;
                end else begin
                    insufficient_d = 1'b1;
                end
            end
        end else if (in_level) begin
            if (fail) begin
                level_time_d = FAIL_T;
            end else if (abort) begin
                level_time_d = 6'd0;
            end else if (sec_tick) begin
                if (!expiring) begin
                    level_time_d = level_time_q - 6'd1;
                end else if (state_q < LAST_LEVEL) begin
                    level_time_d = LEVEL_T;
                end else begin
                    level_time_d = 6'd0;
                    win_d        = 1'b1;
                end
            end
        end else if (state_q == S_FAIL) begin
            if (sec_tick)
                level_time_d = expiring ? 6'd0 : level_time_q - 6'd1;
        end else begin
            level_time_d = 6'd0;
        end
    end

    assign state        = state_q;
    assign level_time   = level_time_q;
    assign ticket       = ticket_q;
    assign win          = win_q;
    assign insufficient = insufficient_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer. It drives the 4-bit `state` bus consumed by the player life/money block and the level logic: 0 = MENU, 1..4 = play levels, 5 = FAIL. It charges an entry ticket against the player's money, times each level from a 1 Hz tick, and advances levels on timer expiry. It reacts to the player's `fail` flag and holds the FAIL screen for a fixed time before returning to MENU.

Parameters:
TICKET_COST, 10, minimum money required to accept start (7-bit compare)
LEVEL_SECS, 30, seconds per level (1..63)
FAIL_SECS, 3, seconds FAIL state is held (1..63)
NUM_LEVELS, 4, last play level (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset, sampled on posedge clk
start  in  1  one-cycle pulse, debounced start button
abort  in  1  one-cycle pulse, quit to MENU
sec_tick  in  1  one-cycle pulse, once per second
fail  in  1  player fail flag (registered upstream, level)
money  in  7  player's current money, 0..99
state  out  4  game state: 0 MENU, 1..4 LEVELn, 5 FAIL
ticket  out  1  one-cycle pulse; player deducts entry cost
level_time  out  6  seconds remaining in current level or FAIL hold
win  out  1  one-cycle pulse on completing the last level
insufficient  out  1  sticky flag: last start was rejected for lack of money

Behaviour:
- Reset (synchronous, overrides everything): state=0, ticket=0, level_time=0, win=0, insufficient=0, internal counters=0.
- All outputs are registered. `ticket` and `win` are high for exactly one cycle.
- MENU (0):
  - start && money>=TICKET_COST: next cycle state=1, level_time=LEVEL_SECS, ticket=1 for that one cycle, insufficient=0.
  - start && money<TICKET_COST: stay 0, no ticket, insufficient=1.
  - fail, abort and sec_tick are ignored in MENU; level_time holds 0.
- LEVELn (1..NUM_LEVELS), one decision per cycle, priority fail > abort > sec_tick:
  - fail=1: state=5, level_time=FAIL_SECS.
  - abort=1: state=0, level_time=0.
  - sec_tick && level_time>1: level_time decrements by 1.
  - sec_tick && level_time==1 && n<NUM_LEVELS: state=n+1, level_time=LEVEL_SECS. No ticket is charged.
  - sec_tick && level_time==1 && n==NUM_LEVELS: state=0, level_time=0, win=1 for one cycle.
  - start is ignored in play.
- FAIL (5):
  - sec_tick && level_time>1: decrement.
  - sec_tick && level_time==1: state=0, level_time=0.
  - start, abort and fail are ignored. Fail clears upstream once state 5/0 zeroes damage; no extra handling is needed here.
- level_time never wraps below 0. Unused state encodings 6..15 recover to 0 on the next cycle.
- The ticket pulse and the state 0→1 transition occur in the same cycle. The upstream block therefore sees ticket while state is already 1.
- Reset asserted mid-level or mid-FAIL returns to MENU in one cycle with no ticket and no win.
- money is sampled only in the cycle start is high. A start and a money change in the same cycle use the pre-change value.

Test Plan:
- Reset, money=20, start pulse → next cycle state=1, ticket=1 for one cycle, level_time=30, insufficient=0.
- MENU, money=9, start pulse → state stays 0, ticket stays 0, insufficient=1. Then money=10 and start → state=1, insufficient=0.
- LEVEL1, apply 30 sec_ticks → level_time counts 30..1, then state=2, level_time=30, no ticket. Repeat through LEVEL4 → state=0, win pulses once.
- LEVEL3 with level_time=1: fail=1 and sec_tick in the same cycle → state=5, level_time=3 (fail wins). Three more ticks → state=0.
- LEVEL2, abort and sec_tick together → state=0, level_time=0. A start in FAIL and in play → no state change, no ticket.
- LEVEL4 mid-count with rst=1 for one cycle → state=0, all outputs 0, no win. A forced illegal state 7 → state=0 on the next cycle.
